l1_event_queue_buffer: RTL and testbench

Per-pixel L1 event buffer, parametrised successor of the single-entry pixel L1 buffer. Every bunch crossing it stores the hit flag and the TDC word into a circular buffer, at the global write address. On an L1 accept it looks up the global read address. A hit found there is captured into a small readout queue, so several L1 accepts can be pending before the switch network drains them. It sits between the pixel circular buffer and the pixel readout switch network.

---
 rtl/l1_event_queue_buffer_pkg.sv | 27 ++
 rtl/l1_event_queue_buffer_if.sv | 48 ++++
 rtl/l1_event_queue_buffer_readout_queue.sv | 70 +++++++
 rtl/l1_event_queue_buffer.sv | 137 +++++++++++++
 tb/tb_l1_event_queue_buffer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/l1_event_queue_buffer_pkg.sv
// -----------------------------------------------------------------------------
// l1_buf_pkg
// Shared definitions for the per-pixel L1 event queue buffer.
//   L1_TAGW  : number of error-tag bits stored alongside each data word.
//   L1_DATAW : default stored data width (TDC data + Hamming).
//   l1_entry_t : layout of one stored/queued entry {data, e2a, e1a}.
//                The RTL uses flat vectors of the same layout so that
//                DATAWIDTH can be overridden; the struct documents field order.
//   qcount_w() : width of a queue occupancy counter for a given depth.
// -----------------------------------------------------------------------------
package l1_buf_pkg;

    localparam int L1_TAGW  = 2;
    localparam int L1_DATAW = 36;

    typedef struct packed {
        logic [L1_DATAW-1:0] data;
        logic                e2a;
        logic                e1a;
    } l1_entry_t;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int qcount_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/l1_event_queue_buffer_if.sv
// -----------------------------------------------------------------------------
// l1_event_queue_buffer_if
// Bus bundle between the pixel circular buffer / global control (write and
// lookup side) and the pixel readout switch network (load/read side).
//   Write side : din, in_hit, wren, wr_addr, e1a, e2a
//   Lookup     : rd_addr, l1a
//   Readout    : load, read -> dout, out_e1a, out_e2a, unread_hit
//   Status     : q_count, q_overflow
// Handshake: load pops the queue head into dout (unread_hit=1 when a word was
// delivered, 0 when the queue was empty); read acknowledges the delivered word
// and clears unread_hit. load takes precedence over read in the same cycle.
// slave  : the buffer's view.   master : the driver's view.
// -----------------------------------------------------------------------------
interface l1_event_queue_buffer_if
    import l1_buf_pkg::*;
#(
    parameter int ADDRWIDTH = 7,
    parameter int DATAWIDTH = 36,
    parameter int QDEPTH    = 4
);
    logic [DATAWIDTH-1:0]        din;
    logic                        in_hit;
    logic                        wren;
    logic [ADDRWIDTH-1:0]        wr_addr;
    logic [ADDRWIDTH-1:0]        rd_addr;
    logic                        l1a;
    logic                        e1a;
    logic                        e2a;
    logic                        load;
    logic                        read;
    logic [DATAWIDTH-1:0]        dout;
    logic                        out_e1a;
    logic                        out_e2a;
    logic                        unread_hit;
    logic [qcount_w(QDEPTH)-1:0] q_count;
    logic                        q_overflow;

    modport slave (
        input  din, in_hit, wren, wr_addr, rd_addr, l1a, e1a, e2a, load, read,
        output dout, out_e1a, out_e2a, unread_hit, q_count, q_overflow
    );

    modport master (
        output din, in_hit, wren, wr_addr, rd_addr, l1a, e1a, e2a, load, read,
        input  dout, out_e1a, out_e2a, unread_hit, q_count, q_overflow
    );

endinterface

// File: rtl/l1_event_queue_buffer_readout_queue.sv
// -----------------------------------------------------------------------------
// l1_readout_queue
// Small synchronous FIFO holding L1-accepted hits until the switch network
// loads them.
//   clk, reset : clock, synchronous active-low reset (empties the queue)
//   push, push_data : enqueue request and word
//   pop        : dequeue request (ignored when empty)
//   head       : current head word (valid when !empty)
//   count      : occupancy 0..QDEPTH
//   full, empty: status
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is silently dropped (the caller flags the overflow).
// -----------------------------------------------------------------------------
module l1_readout_queue
    import l1_buf_pkg::*;
#(
    parameter int WIDTH  = 38,
    parameter int QDEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic [qcount_w(QDEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = qcount_w(QDEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    logic [WIDTH-1:0] mem [0:QDEPTH-1];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // When full, the slot freed by a same-cycle pop is the one written.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // QDEPTH is a power of 2, so pointers wrap by overflow.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (reset && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/l1_event_queue_buffer.sv
// -----------------------------------------------------------------------------
// l1_event_queue_buffer
// Per-pixel L1 event buffer. Each bunch crossing the (registered) hit flag and
// TDC word are written into a circular buffer at the global write address.
// An L1 accept looks up the global read address; a hit found there is queued
// for the readout switch network, allowing several pending L1 accepts.
//   clk   : 40 MHz clock
//   reset : synchronous, active-low
//   bus   : l1_event_queue_buffer_if.slave
//           din/in_hit/wren/wr_addr/e1a/e2a : write side (registered 1 cycle)
//           rd_addr/l1a                     : L1 lookup
//           load/read -> dout/out_e1a/out_e2a/unread_hit : readout
//           q_count/q_overflow              : queue status
// -----------------------------------------------------------------------------
module l1_event_queue_buffer
    import l1_buf_pkg::*;
#(
    parameter int ADDRWIDTH = 7,
    parameter int DATAWIDTH = 36,
    parameter int QDEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    l1_event_queue_buffer_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDRWIDTH;
    localparam int EW    = DATAWIDTH + L1_TAGW;
    localparam int CW    = qcount_w(QDEPTH);

    // Input stage
    logic                 in_hit_d;
    logic                 wren_d;
    logic [DATAWIDTH-1:0] din_d;
    logic                 e1a_d;
    logic                 e2a_d;
    logic [ADDRWIDTH-1:0] wr_addr_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_hit_d  <= 1'b0;
            wren_d    <= 1'b0;
            din_d     <= '0;
            e1a_d     <= 1'b0;
            e2a_d     <= 1'b0;
            wr_addr_d <= '0;
        end else begin
            in_hit_d  <= bus.in_hit;
            wren_d    <= bus.wren;
            din_d     <= bus.din;
            e1a_d     <= bus.e1a;
            e2a_d     <= bus.e2a;
            wr_addr_d <= bus.wr_addr;
        end
    end

    // Circular buffer: hit bitmap is reset so stale hits cannot survive a
    // reset; the data array only matters where the bitmap is set.
    logic [DEPTH-1:0] hit_mem;
    logic [EW-1:0]    data_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_mem <= '0;
        end else if (wren_d) begin
            hit_mem[wr_addr_d] <= in_hit_d;
        end
    end

    // Non-hit crossings leave the old data in place; only the flag changes.
    always_ff @(posedge clk) begin
        if (reset && wren_d && in_hit_d) begin
            data_mem[wr_addr_d] <= {din_d, e2a_d, e1a_d};
        end
    end

    // Lookup reads the registers before this edge's write, so a same-cycle
    // collision on rd_addr == wr_addr_d returns the old contents.
    logic          lk_hit;
    logic [EW-1:0] lk_entry;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;

    assign lk_hit   = hit_mem[bus.rd_addr];
    assign lk_entry = data_mem[bus.rd_addr];
    assign push     = bus.l1a && lk_hit;
    assign pop      = bus.load && !q_empty;

    l1_readout_queue #(
        .WIDTH  (EW),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (lk_entry),
        .pop       (pop),
        .head      (head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign bus.q_count = q_count;

    // Output stage. The queue has no bypass: a word pushed this edge is only
    // visible to load from the next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.dout       <= '0;
            bus.out_e1a    <= 1'b0;
            bus.out_e2a    <= 1'b0;
            bus.unread_hit <= 1'b0;
            bus.q_overflow <= 1'b0;
        end else begin
            if (push && q_full && !pop) bus.q_overflow <= 1'b1;

            if (bus.load) begin
                if (!q_empty) begin
                    bus.dout       <= head[EW-1:L1_TAGW];
                    bus.out_e2a    <= head[1];
                    bus.out_e1a    <= head[0];
                    bus.unread_hit <= 1'b1;
                end else begin
                    bus.unread_hit <= 1'b0;
                end
            end else if (bus.read) begin
                bus.unread_hit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l1_event_queue_buffer.sv
// -----------------------------------------------------------------------------
// tb_l1_event_queue_buffer
// Directed self-checking bench for l1_event_queue_buffer (ADDRWIDTH=7,
// DATAWIDTH=36, QDEPTH=4). Inputs change 1 ns after posedge; outputs are
// sampled at the same point, reflecting the edge just taken.
// -----------------------------------------------------------------------------
module tb_l1_event_queue_buffer;

    localparam int AW = 7;
    localparam int DW = 36;
    localparam int QD = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    l1_event_queue_buffer_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .QDEPTH(QD)) bus ();

    l1_event_queue_buffer #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .QDEPTH(QD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Write takes effect in the buffer at the second edge (input stage).
    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic h, input logic e1, input logic e2);
        bus.wren    = 1'b1;
        bus.wr_addr = a;
        bus.din     = d;
        bus.in_hit  = h;
        bus.e1a     = e1;
        bus.e2a     = e2;
        step();
        bus.wren    = 1'b0;
        bus.in_hit  = 1'b0;
        step();
    endtask

    task automatic l1_lookup(input logic [AW-1:0] a);
        bus.l1a     = 1'b1;
        bus.rd_addr = a;
        step();
        bus.l1a     = 1'b0;
    endtask

    task automatic do_load();
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_read();
        bus.read = 1'b1;
        step();
        bus.read = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL reset_q_count: got %0d want 0", bus.q_count); end
        checks++; if (bus.q_overflow !== 1'b0) begin errors++; $display("FAIL reset_q_overflow: got %b want 0", bus.q_overflow); end
        checks++; if (bus.unread_hit !== 1'b0) begin errors++; $display("FAIL reset_unread_hit: got %b want 0", bus.unread_hit); end
        checks++; if (bus.dout !== 36'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
        checks++; if (bus.out_e1a !== 1'b0) begin errors++; $display("FAIL reset_out_e1a: got %b want 0", bus.out_e1a); end
        checks++; if (bus.out_e2a !== 1'b0) begin errors++; $display("FAIL reset_out_e2a: got %b want 0", bus.out_e2a); end
    endtask

    task automatic test_basic();
        write_word(7'd5, 36'h123456789, 1'b1, 1'b1, 1'b0);
        l1_lookup(7'd5);
        checks++; if (bus.q_count !== 3'd1) begin errors++; $display("FAIL basic_q_after_l1a: got %0d want 1", bus.q_count); end
        do_load();
        checks++; if (bus.dout !== 36'h123456789) begin errors++; $display("FAIL basic_dout: got %h want 123456789", bus.dout); end
        checks++; if (bus.out_e1a !== 1'b1) begin errors++; $display("FAIL basic_out_e1a: got %b want 1", bus.out_e1a); end
        checks++; if (bus.out_e2a !== 1'b0) begin errors++; $display("FAIL basic_out_e2a: got %b want 0", bus.out_e2a); end
        checks++; if (bus.unread_hit !== 1'b1) begin errors++; $display("FAIL basic_unread_set: got %b want 1", bus.unread_hit); end
        checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL basic_q_after_load: got %0d want 0", bus.q_count); end
        do_read();
        checks++; if (bus.unread_hit !== 1'b0) begin errors++; $display("FAIL basic_unread_clear: got %b want 0", bus.unread_hit); end
    endtask

    task automatic test_no_hit();
        // A hit at 9 overwritten by a non-hit crossing must not be found.
        write_word(7'd9, 36'hFEDCBA987, 1'b1, 1'b0, 1'b1);
        write_word(7'd9, 36'h000000111, 1'b0, 1'b0, 1'b0);
        l1_lookup(7'd9);
        checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL nohit_q_count: got %0d want 0", bus.q_count); end
        do_load();
        checks++; if (bus.unread_hit !== 1'b0) begin errors++; $display("FAIL nohit_unread: got %b want 0", bus.unread_hit); end
        checks++; if (bus.dout !== 36'h123456789) begin errors++; $display("FAIL nohit_dout_held: got %h want 123456789", bus.dout); end
    endtask

    task automatic test_queue_fill();
        logic [DW-1:0] w [5];
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            w[i] = 36'hA00000000 + 36'(i * 17 + 1);
            write_word(7'(20 + i), w[i], 1'b1, i[0], i[1]);
        end
        for (int i = 0; i < 5; i++) l1_lookup(7'(20 + i));
        checks++; if (bus.q_count !== 3'd4) begin errors++; $display("FAIL fill_q_count: got %0d want 4", bus.q_count); end
        checks++; if (bus.q_overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b want 1", bus.q_overflow); end
        for (int i = 0; i < 4; i++) begin
            do_load();
            checks++; if (bus.dout !== w[i] || bus.out_e1a !== i[0] || bus.out_e2a !== i[1]) begin
                errors++; $display("FAIL fill_order[%0d]: got %h/%b/%b want %h/%b/%b", i, bus.dout, bus.out_e2a, bus.out_e1a, w[i], i[1], i[0]);
            end
        end
        do_load();
        checks++; if (bus.unread_hit !== 1'b0) begin errors++; $display("FAIL fill_fifth_absent: got unread %b want 0", bus.unread_hit); end
        checks++; if (bus.dout !== w[3]) begin errors++; $display("FAIL fill_dout_held: got %h want %h", bus.dout, w[3]); end
        checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL fill_q_drained: got %0d want 0", bus.q_count); end
        checks++; if (bus.q_overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_sticky: got %b want 1", bus.q_overflow); end
    endtask

    task automatic test_push_pop_full();
        logic [DW-1:0] w [5];
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            w[i] = 36'h5B0000000 + 36'(i * 3 + 2);
            write_word(7'(40 + i), w[i], 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 4; i++) l1_lookup(7'(40 + i));
        checks++; if (bus.q_count !== 3'd4) begin errors++; $display("FAIL pp_q_full: got %0d want 4", bus.q_count); end
        bus.l1a     = 1'b1;
        bus.rd_addr = 7'd44;
        bus.load    = 1'b1;
        step();
        bus.l1a     = 1'b0;
        bus.load    = 1'b0;
        checks++; if (bus.q_count !== 3'd4) begin errors++; $display("FAIL pp_q_unchanged: got %0d want 4", bus.q_count); end
        checks++; if (bus.q_overflow !== 1'b0) begin errors++; $display("FAIL pp_no_overflow: got %b want 0", bus.q_overflow); end
        checks++; if (bus.dout !== w[0]) begin errors++; $display("FAIL pp_first_out: got %h want %h", bus.dout, w[0]); end
        for (int i = 1; i < 5; i++) begin
            do_load();
            checks++; if (bus.dout !== w[i] || bus.out_e2a !== 1'b1) begin
                errors++; $display("FAIL pp_order[%0d]: got %h e2a %b want %h e2a 1", i, bus.dout, bus.out_e2a, w[i]);
            end
        end
        checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL pp_q_drained: got %0d want 0", bus.q_count); end
    endtask

    task automatic test_collision();
        apply_reset();
        write_word(7'd3, 36'h0000AAAAA, 1'b1, 1'b1, 1'b1);
        // Write B to addr 3; its buffer write lands on the edge of the l1a.
        bus.wren    = 1'b1;
        bus.wr_addr = 7'd3;
        bus.din     = 36'h0000BBBBB;
        bus.in_hit  = 1'b1;
        bus.e1a     = 1'b0;
        bus.e2a     = 1'b0;
        step();
        bus.wren    = 1'b0;
        bus.in_hit  = 1'b0;
        l1_lookup(7'd3);
        checks++; if (bus.q_count !== 3'd1) begin errors++; $display("FAIL coll_q_count: got %0d want 1", bus.q_count); end
        do_load();
        checks++; if (bus.dout !== 36'h0000AAAAA || bus.out_e1a !== 1'b1) begin
            errors++; $display("FAIL coll_old_data: got %h e1a %b want 0000aaaaa e1a 1", bus.dout, bus.out_e1a);
        end
        l1_lookup(7'd3);
        do_load();
        checks++; if (bus.dout !== 36'h0000BBBBB || bus.out_e1a !== 1'b0) begin
            errors++; $display("FAIL coll_new_data: got %h e1a %b want 0000bbbbb e1a 0", bus.dout, bus.out_e1a);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) write_word(7'(60 + i), 36'h777000000 + 36'(i), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) l1_lookup(7'(60 + i));
        do_load();
        checks++; if (bus.q_count !== 3'd2 || bus.unread_hit !== 1'b1) begin
            errors++; $display("FAIL rst_setup: got q %0d unread %b want q 2 unread 1", bus.q_count, bus.unread_hit);
        end
        apply_reset();
        checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL rst_q_count: got %0d want 0", bus.q_count); end
        checks++; if (bus.unread_hit !== 1'b0) begin errors++; $display("FAIL rst_unread: got %b want 0", bus.unread_hit); end
        checks++; if (bus.dout !== 36'h0 || bus.out_e1a !== 1'b0) begin errors++; $display("FAIL rst_dout: got %h e1a %b want 0 e1a 0", bus.dout, bus.out_e1a); end
        l1_lookup(7'd60);
        checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL rst_stale_hit: got %0d want 0", bus.q_count); end
        do_load();
        checks++; if (bus.unread_hit !== 1'b0) begin errors++; $display("FAIL rst_stale_load: got %b want 0", bus.unread_hit); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        bus.din     = '0;
        bus.in_hit  = 1'b0;
        bus.wren    = 1'b0;
        bus.wr_addr = '0;
        bus.rd_addr = '0;
        bus.l1a     = 1'b0;
        bus.e1a     = 1'b0;
        bus.e2a     = 1'b0;
        bus.load    = 1'b0;
        bus.read    = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        test_reset();
        test_basic();
        test_no_hit();
        test_queue_fill();
        test_push_pop_full();
        test_collision();
        test_mid_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
